demux1to4_buf: RTL and testbench
================================

DEMUX1TO4_BUF -- requirements
Module: demux1to4_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output lane FIFO (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  word to route.
REQ-008 SHALL have port in_select  input  2  destination lane 0..3.
REQ-009 SHALL have port out_valid  output  4  per-lane word present, bit k = lane k.
REQ-010 SHALL have port out_ready  input  4  per-lane downstream accept.
REQ-011 SHALL have ports out_data0..out_data3  output  WIDTH  each  head word of lanes 0..3.
REQ-012 SHALL have port lane_full  output  4  per-lane FIFO holds DEPTH words.

Function
REQ-013 Input transfer SHALL occur on a cycle where in_valid && in_ready; output transfer on lane k where out_valid[k] && out_ready[k].
REQ-014 in_ready SHALL equal !lane_full[in_select], combinational from in_select and registered lane state only.
REQ-015 An accepted word SHALL be written only to the FIFO of lane in_select; other lanes unchanged.
REQ-016 Latency SHALL be one cycle: word accepted at edge N is visible on out_dataK with out_valid[K]=1 after edge N; no same-cycle pass-through.
REQ-017 Each lane SHALL deliver words in acceptance order; no ordering guarantee across lanes.
REQ-018 out_valid[k] SHALL be 1 iff lane k count > 0; out_dataK SHALL be stable while out_valid[k] && !out_ready[k].
REQ-019 Lane count SHALL be 0..DEPTH; push only: +1; pop only: -1; push and pop same lane same cycle: unchanged, head advances, new word at tail.
REQ-020 Full lane: in_ready=0 for that select even if out_ready[k]=1 the same cycle; word held upstream, accepted next cycle.
REQ-021 Empty lane: out_ready[k] ignored; no pointer change.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-023 Pops on different lanes in the same cycle SHALL all complete independently.
REQ-024 in_data/in_select SHALL be ignored when in_valid=0.

Reset
REQ-025 While rst_n=0 at a rising edge: all lane counts and pointers 0, out_valid=4'b0000, lane_full=4'b0000, in_ready=1.
REQ-026 Reset mid-operation SHALL discard all buffered words; no transfer is recognised on the reset edge.
REQ-027 out_dataK values after reset are don't-care while out_valid[k]=0.

Structure
REQ-028 Lane count (4), select width (2) and default WIDTH/DEPTH SHALL be constants in a shared package demux_pkg.
REQ-029 One sub-module demux_lane_fifo (WIDTH, DEPTH; push, pop, din, dout, empty, full) SHALL be instantiated four times; top holds only select decode and in_ready mux.

Verification
REQ-030 Reset then in_data=4095, in_select=0, one valid cycle, out_ready=0 -> out_valid=4'b0001, out_data0=4095 next cycle, held stable.
REQ-031 Push 4095/61455/12345/20197 to lanes 0/1/2/3, all out_ready=1 -> each lane emits its word exactly once, one cycle after acceptance.
REQ-032 Lane 2, out_ready[2]=0, push 1,2,3 -> 1,2 accepted, lane_full=4'b0100, in_ready=0 for 3; raise out_ready[2] -> 3 accepted one cycle after; lane 2 emits 1,2,3 in order.
REQ-033 Lane 1 count 1, simultaneous push 7 and pop -> count stays 1, out_data1=7 next cycle.
REQ-034 Lanes 0 and 3 full, rst_n=0 one edge -> out_valid=0, lane_full=0, in_ready=1; no stale word emitted afterwards.
REQ-035 Random traffic 10000 cycles, random out_ready -> per-lane scoreboard matches, no loss, duplication or reordering.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the 1-to-4 buffered demux
// Purpose: lane count, select width and default geometry shared by the
//          interface, the lane FIFO and the top level.
// Ports:   none (package).
package demux_pkg;

    localparam int LANES     = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;

    // One-hot lane mask for a select value.
    function automatic logic [LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/demux1to4_buf_if.sv
// rtl/demux1to4_buf_if.sv - upstream/downstream handshake bundle for demux1to4_buf
// Purpose: groups the single input stream and the four output lanes.
// Signals: in_valid/in_ready/in_data/in_select (upstream word and destination),
//          out_valid/out_ready (per-lane handshake, bit k = lane k),
//          out_data0..out_data3 (lane head words), lane_full (per-lane full flag).
// Modports: slave (the demux), master (the environment driving it).
interface demux1to4_buf_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_select;
    logic [LANES-1:0] out_valid;
    logic [LANES-1:0] out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [LANES-1:0] lane_full;

    modport slave (
        input  in_valid, in_data, in_select, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, lane_full
    );

    modport master (
        output in_valid, in_data, in_select, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, lane_full
    );
endinterface

// File: rtl/demux_lane_fifo.sv
// rtl/demux_lane_fifo.sv - per-lane synchronous FIFO with head-word output
// Purpose: buffers up to DEPTH words for one output lane; dout always shows the
//          oldest word, so it stays stable until that word is popped.
// Ports: clk, rst_n (sync active-low), push/din (write), pop (read, ignored when
//        empty), dout (head word), empty, full.
module demux_lane_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // Upstream already holds words for a full lane; this guard keeps the FIFO
    // safe on its own.
    assign do_push = push && !full;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/demux1to4_buf.sv
// rtl/demux1to4_buf.sv - 1-to-4 demultiplexer with a small FIFO per output lane
// Purpose: routes each accepted upstream word to the lane named by in_select;
//          words appear on that lane one cycle after acceptance.
// Ports: clk, rst_n (sync active-low), bus (demux1to4_buf_if.slave: input
//        stream, four output lanes, per-lane full flags).
module demux1to4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    demux1to4_buf_if.slave    bus
);
    logic [LANES-1:0] lane_push;
    logic [LANES-1:0] lane_empty;
    logic [LANES-1:0] lane_full_w;
    logic [WIDTH-1:0] lane_dout [LANES];
    logic             in_ready_w;

    // Readiness depends only on the selected lane's registered fill state, so a
    // same-cycle pop on a full lane does not open it for a push.
    assign in_ready_w = !lane_full_w[bus.in_select];
    assign lane_push  = (bus.in_valid && in_ready_w) ? sel_onehot(bus.in_select) : '0;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (lane_push[k]),
            .pop   (bus.out_ready[k]),
            .din   (bus.in_data),
            .dout  (lane_dout[k]),
            .empty (lane_empty[k]),
            .full  (lane_full_w[k])
        );
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = ~lane_empty;
    assign bus.lane_full = lane_full_w;
    assign bus.out_data0 = lane_dout[0];
    assign bus.out_data1 = lane_dout[1];
    assign bus.out_data2 = lane_dout[2];
    assign bus.out_data3 = lane_dout[3];

endmodule

// File: tb/tb_demux1to4_buf.sv
// tb/tb_demux1to4_buf.sv - self-checking bench for demux1to4_buf
module tb_demux1to4_buf;
    import demux_pkg::*;

    localparam int WIDTH = DEF_WIDTH;
    localparam int DEPTH = DEF_DEPTH;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    demux1to4_buf_if #(.WIDTH(WIDTH)) intf ();

    demux1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    logic [WIDTH-1:0] od [LANES];
    always_comb begin
        od[0] = intf.out_data0;
        od[1] = intf.out_data1;
        od[2] = intf.out_data2;
        od[3] = intf.out_data3;
    end

    // Reference: one ordered queue of buffered words per lane.
    logic [WIDTH-1:0] mq [LANES][$];

    // Advance one clock; the model applies the same edge's transfers.
    task automatic tick();
        logic             acc;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] dat;
        logic [LANES-1:0] ordy;
        sel  = intf.in_select;
        dat  = intf.in_data;
        ordy = intf.out_ready;
        acc  = intf.in_valid && (mq[sel].size() < DEPTH);
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < LANES; k++)
                if (ordy[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            if (acc) mq[sel].push_back(dat);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        intf.in_valid = 1'b0;
        intf.out_ready = '0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        intf.in_valid = 1'b1;
        intf.in_select = 2'd3;
        intf.in_data = 16'hBEEF;
        intf.out_ready = '0;
        tick();
        tick();
        intf.in_valid = 1'b0;
        #1;
        total++; if (intf.out_valid !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b exp=0000", intf.out_valid); end
        total++; if (intf.lane_full !== 4'b0000) begin bad++; $display("FAIL reset_lane_full got=%b exp=0000", intf.lane_full); end
        total++; if (intf.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", intf.in_ready); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        intf.in_valid = 1'b1; intf.in_data = 16'd4095; intf.in_select = 2'd0; intf.out_ready = '0;
        #1;
        total++; if (intf.in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b exp=1", intf.in_ready); end
        tick();
        intf.in_valid = 1'b0; intf.in_data = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (intf.out_valid !== 4'b0001) begin bad++; $display("FAIL single_out_valid cyc=%0d got=%b exp=0001", i, intf.out_valid); end
            total++; if (intf.out_data0 !== 16'd4095) begin bad++; $display("FAIL single_out_data0 cyc=%0d got=%0d exp=4095", i, intf.out_data0); end
            tick();
        end
    endtask

    task automatic test_all_lanes();
        logic [WIDTH-1:0] w [LANES];
        w[0] = 16'd4095; w[1] = 16'd61455; w[2] = 16'd12345; w[3] = 16'd20197;
        do_reset();
        intf.out_ready = 4'hF;
        for (int k = 0; k < LANES; k++) begin
            intf.in_valid = 1'b1; intf.in_select = SEL_W'(k); intf.in_data = w[k];
            tick();
            total++; if (intf.out_valid !== 4'(1 << k)) begin bad++; $display("FAIL lanes_out_valid lane=%0d got=%b exp=%b", k, intf.out_valid, 4'(1 << k)); end
            total++; if (od[k] !== w[k]) begin bad++; $display("FAIL lanes_out_data lane=%0d got=%0d exp=%0d", k, od[k], w[k]); end
        end
        intf.in_valid = 1'b0;
        tick();
        total++; if (intf.out_valid !== 4'b0000) begin bad++; $display("FAIL lanes_drained got=%b exp=0000", intf.out_valid); end
    endtask

    task automatic test_full();
        do_reset();
        intf.out_ready = '0;
        intf.in_valid = 1'b1; intf.in_select = 2'd2; intf.in_data = 16'd1;
        tick();
        intf.in_data = 16'd2;
        tick();
        intf.in_data = 16'd3;
        #1;
        total++; if (intf.lane_full !== 4'b0100) begin bad++; $display("FAIL full_lane_full got=%b exp=0100", intf.lane_full); end
        total++; if (intf.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", intf.in_ready); end
        total++; if (intf.out_data2 !== 16'd1) begin bad++; $display("FAIL full_head1 got=%0d exp=1", intf.out_data2); end
        intf.out_ready = 4'b0100;
        #1;
        total++; if (intf.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready_with_pop got=%b exp=0", intf.in_ready); end
        tick();
        total++; if (intf.in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready_after got=%b exp=1", intf.in_ready); end
        total++; if (intf.out_data2 !== 16'd2) begin bad++; $display("FAIL full_head2 got=%0d exp=2", intf.out_data2); end
        tick();
        intf.in_valid = 1'b0;
        #1;
        total++; if (intf.out_valid !== 4'b0100) begin bad++; $display("FAIL full_valid3 got=%b exp=0100", intf.out_valid); end
        total++; if (intf.out_data2 !== 16'd3) begin bad++; $display("FAIL full_head3 got=%0d exp=3", intf.out_data2); end
        tick();
        total++; if (intf.out_valid !== 4'b0000) begin bad++; $display("FAIL full_drained got=%b exp=0000", intf.out_valid); end
    endtask

    task automatic test_push_pop();
        do_reset();
        intf.out_ready = '0;
        intf.in_valid = 1'b1; intf.in_select = 2'd1; intf.in_data = 16'd5;
        tick();
        intf.in_data = 16'd7; intf.out_ready = 4'b0010;
        #1;
        total++; if (intf.in_ready !== 1'b1) begin bad++; $display("FAIL pushpop_in_ready got=%b exp=1", intf.in_ready); end
        tick();
        intf.in_valid = 1'b0; intf.out_ready = '0;
        #1;
        total++; if (intf.out_valid !== 4'b0010) begin bad++; $display("FAIL pushpop_valid got=%b exp=0010", intf.out_valid); end
        total++; if (intf.out_data1 !== 16'd7) begin bad++; $display("FAIL pushpop_data got=%0d exp=7", intf.out_data1); end
        total++; if (intf.lane_full !== 4'b0000) begin bad++; $display("FAIL pushpop_full got=%b exp=0000", intf.lane_full); end
        intf.out_ready = 4'b0010;
        tick();
        total++; if (intf.out_valid !== 4'b0000) begin bad++; $display("FAIL pushpop_count1 got=%b exp=0000", intf.out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        intf.out_ready = '0;
        intf.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            intf.in_select = (i < 2) ? 2'd0 : 2'd3;
            intf.in_data = 16'(100 + i);
            tick();
        end
        #1;
        total++; if (intf.lane_full !== 4'b1001) begin bad++; $display("FAIL mid_full_before got=%b exp=1001", intf.lane_full); end
        rst_n = 1'b0; intf.in_select = 2'd1; intf.in_data = 16'd999; intf.out_ready = 4'hF;
        tick();
        rst_n = 1'b1; intf.in_valid = 1'b0;
        #1;
        total++; if (intf.out_valid !== 4'b0000) begin bad++; $display("FAIL mid_out_valid got=%b exp=0000", intf.out_valid); end
        total++; if (intf.lane_full !== 4'b0000) begin bad++; $display("FAIL mid_lane_full got=%b exp=0000", intf.lane_full); end
        total++; if (intf.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", intf.in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (intf.out_valid !== 4'b0000) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b exp=0000", i, intf.out_valid); end
        end
    endtask

    task automatic test_random();
        logic exp_b;
        do_reset();
        for (int i = 0; i < 10000 && bad < 20; i++) begin
            intf.in_valid  = ($urandom_range(0, 3) != 0);
            intf.in_select = SEL_W'($urandom_range(0, 3));
            intf.in_data   = WIDTH'($urandom);
            intf.out_ready = LANES'($urandom);
            #1;
            exp_b = (mq[intf.in_select].size() < DEPTH);
            total++; if (intf.in_ready !== exp_b) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, intf.in_ready, exp_b); end
            for (int k = 0; k < LANES; k++) begin
                exp_b = (mq[k].size() > 0);
                total++; if (intf.out_valid[k] !== exp_b) begin bad++; $display("FAIL rnd_out_valid cyc=%0d lane=%0d got=%b exp=%b", i, k, intf.out_valid[k], exp_b); end
                exp_b = (mq[k].size() == DEPTH);
                total++; if (intf.lane_full[k] !== exp_b) begin bad++; $display("FAIL rnd_lane_full cyc=%0d lane=%0d got=%b exp=%b", i, k, intf.lane_full[k], exp_b); end
                if (mq[k].size() > 0) begin
                    total++; if (od[k] !== mq[k][0]) begin bad++; $display("FAIL rnd_out_data cyc=%0d lane=%0d got=%0d exp=%0d", i, k, od[k], mq[k][0]); end
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        intf.in_valid = 1'b0;
        intf.in_data = '0;
        intf.in_select = '0;
        intf.out_ready = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_lanes();
        test_full();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
